// File: rtl/mtl_lcd_ctrl.sv
// rtl/mtl_lcd_ctrl.sv - LCD timing generator with 2x2-scaled NES frame-buffer readout
// Stage 0 counters/read request, stage 1 frame-buffer data, stage 2 palette, stage 3 outputs.
module mtl_lcd_ctrl #(
   parameter int H_TOTAL = 1056,
   parameter int V_TOTAL = 525,
   parameter int H_ACT0  = 50,
   parameter int V_ACT0  = 23,
   parameter int H_SYNC  = 30,
   parameter int V_SYNC  = 13
) (
   input  logic       i_lcd_clk,
   input  logic       i_rst,
   input  logic       i_en,
   output logic [7:0] o_pix_rx,
   output logic [7:0] o_pix_ry,
   output logic       o_pix_rd,
   input  logic [5:0] i_pix_idx,
   output logic       o_hsd,
   output logic       o_vsd,
   output logic [7:0] o_r,
   output logic [7:0] o_g,
   output logic [7:0] o_b,
   output logic       o_frame_start
);

   // Counters are at least 10 bits so the NES offset arithmetic always has room.
   localparam int XW = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
   localparam int YW = ($clog2(V_TOTAL) > 10) ? $clog2(V_TOTAL) : 10;

   localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
   localparam logic [XW-1:0] NES_X0 = XW'(H_ACT0 + 144);
   localparam logic [XW-1:0] NES_X1 = XW'(H_ACT0 + 655);
   localparam logic [YW-1:0] NES_Y0 = YW'(V_ACT0);
   localparam logic [YW-1:0] NES_Y1 = YW'(V_ACT0 + 479);
   localparam logic [XW-1:0] HS_END = XW'(H_SYNC);
   localparam logic [YW-1:0] VS_END = YW'(V_SYNC);

   localparam logic [23:0] PALETTE [64] = '{
      24'h666666, 24'h002A88, 24'h1412A7, 24'h3B00A4, 24'h5C007E, 24'h6E0040, 24'h6C0600, 24'h561D00,
      24'h333500, 24'h0B4800, 24'h005200, 24'h004F08, 24'h00404D, 24'h000000, 24'h000000, 24'h000000,
      24'hADADAD, 24'h155FD9, 24'h4240FF, 24'h7527FE, 24'hA01ACC, 24'hB71E7B, 24'hB21030, 24'h994E00,
      24'h6B6D00, 24'h388700, 24'h0C9300, 24'h008F32, 24'h007C8D, 24'h000000, 24'h000000, 24'h000000,
      24'hFFFFFF, 24'h64B0FF, 24'h9290FF, 24'hC676FF, 24'hF36AFF, 24'hFE6ECC, 24'hFE8170, 24'hEA9E22,
      24'hBCBE00, 24'h88D800, 24'h5CE430, 24'h45E082, 24'h48CDDE, 24'h4F4F4F, 24'h000000, 24'h000000,
      24'hFFFFFF, 24'hC0DFFF, 24'hD3D2FF, 24'hE8C8FF, 24'hFBC2FF, 24'hFEC4EA, 24'hFECCC5, 24'hF7D8A5,
      24'hE4E594, 24'hCFEF96, 24'hBDF4AB, 24'hB3F3CC, 24'hB5EBF2, 24'hB8B8B8, 24'h000000, 24'h000000
   };

   logic [XW-1:0] xcnt, x_nxt, s1_x, s2_x;
   logic [YW-1:0] line, y_nxt, s1_y, s2_y;
   logic          nes_nxt;
   logic          s1_nes, s2_nes, s1_v, s2_v;
   logic [23:0]   s2_rgb;

   // Read request is registered from the next counter value so it lines up with xcnt.
   always_comb begin
      x_nxt = xcnt + 1'b1;
      y_nxt = line;
      if (xcnt == X_LAST) begin
         x_nxt = '0;
         y_nxt = (line == Y_LAST) ? '0 : line + 1'b1;
      end
      nes_nxt = (x_nxt >= NES_X0) && (x_nxt <= NES_X1) &&
                (y_nxt >= NES_Y0) && (y_nxt <= NES_Y1);
   end

   always_ff @(posedge i_lcd_clk or posedge i_rst) begin
      if (i_rst) begin
         xcnt          <= '0;
         line          <= '0;
         o_pix_rd      <= 1'b0;
         o_pix_rx      <= '0;
         o_pix_ry      <= '0;
         s1_x          <= '0;
         s1_y          <= '0;
         s1_nes        <= 1'b0;
         s1_v          <= 1'b0;
         s2_x          <= '0;
         s2_y          <= '0;
         s2_nes        <= 1'b0;
         s2_v          <= 1'b0;
         s2_rgb        <= '0;
         o_hsd         <= 1'b1;
         o_vsd         <= 1'b1;
         o_frame_start <= 1'b0;
         o_r           <= '0;
         o_g           <= '0;
         o_b           <= '0;
      end else begin
         xcnt     <= x_nxt;
         line     <= y_nxt;
         o_pix_rd <= nes_nxt;
         if (nes_nxt) begin
            o_pix_rx <= 8'((x_nxt - NES_X0) >> 1);
            o_pix_ry <= 8'((y_nxt - NES_Y0) >> 1);
         end

         s1_x   <= xcnt;
         s1_y   <= line;
         s1_nes <= o_pix_rd;
         s1_v   <= 1'b1;

         s2_x   <= s1_x;
         s2_y   <= s1_y;
         s2_nes <= s1_nes;
         s2_v   <= s1_v;
         s2_rgb <= PALETTE[i_pix_idx];

         // Until a real coordinate reaches stage 3 the outputs keep their idle values.
         o_hsd         <= !s2_v || (s2_x >= HS_END);
         o_vsd         <= !s2_v || (s2_y >= VS_END);
         o_frame_start <= s2_v && (s2_x == '0) && (s2_y == '0);
         {o_r, o_g, o_b} <= (i_en && s2_nes) ? s2_rgb : 24'h000000;
      end
   end

endmodule

// File: tb/tb_mtl_lcd_ctrl.sv
// tb/tb_mtl_lcd_ctrl.sv - scoreboard bench for mtl_lcd_ctrl with reduced frame geometry
module tb_mtl_lcd_ctrl;
   localparam int H_TOTAL = 700;
   localparam int V_TOTAL = 12;
   localparam int H_ACT0  = 20;
   localparam int V_ACT0  = 4;
   localparam int H_SYNC  = 8;
   localparam int V_SYNC  = 2;
   localparam int FRAME   = H_TOTAL * V_TOTAL;

   logic       i_lcd_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_en = 1'b1;
   logic [5:0] i_pix_idx = '0;
   logic [7:0] o_pix_rx, o_pix_ry, o_r, o_g, o_b;
   logic       o_pix_rd, o_hsd, o_vsd, o_frame_start;

   mtl_lcd_ctrl #(
      .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_ACT0(H_ACT0),
      .V_ACT0(V_ACT0), .H_SYNC(H_SYNC), .V_SYNC(V_SYNC)
   ) dut (
      .i_lcd_clk(i_lcd_clk), .i_rst(i_rst), .i_en(i_en),
      .o_pix_rx(o_pix_rx), .o_pix_ry(o_pix_ry), .o_pix_rd(o_pix_rd),
      .i_pix_idx(i_pix_idx), .o_hsd(o_hsd), .o_vsd(o_vsd),
      .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_frame_start(o_frame_start)
   );

   always #5 i_lcd_clk = ~i_lcd_clk;

   typedef struct packed {
      logic        hsd;
      logic        vsd;
      logic        fs;
      logic [23:0] rgb;
   } exp_t;

   exp_t q[$];
   int   edges = 0;
   int   errors = 0;
   int   checks = 0;
   int   mode = 0;
   int   seed = 0;
   logic en_s = 1'b1;
   int   last_rx = 0, last_ry = 0;
   int   rd_cnt = 0, fs_last = -1, hs_low = 0, vs_low = 0;
   int   rd_exp_frame;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
      end
   endtask

   function automatic logic in_nes(input int x, input int y);
      return (x >= H_ACT0 + 144) && (x <= H_ACT0 + 655) && (y >= V_ACT0) && (y <= V_ACT0 + 479);
   endfunction

   function automatic logic [5:0] fb_idx(input int col, input int row);
      int s;
      case (mode)
         0: return 6'h30;
         1: return (col == 255) ? 6'h16 : ((col % 2 == 1) ? 6'h20 : 6'h0F);
         default: begin
            s = ((col * 37) ^ (row * 11) ^ seed) & 3;
            case (s)
               0: return 6'h0F;
               1: return 6'h20;
               2: return 6'h30;
               default: return 6'h16;
            endcase
         end
      endcase
   endfunction

   function automatic logic [23:0] pal_ref(input logic [5:0] idx);
      case (idx)
         6'h0F:        return 24'h000000;
         6'h20, 6'h30: return 24'hFFFFFF;
         6'h16:        return 24'hB21030;
         default:      return 24'hDEAD00;
      endcase
   endfunction

   // Expected output for the n-th pixel clock since reset release.
   function automatic exp_t model(input int n);
      exp_t e;
      int x, y;
      x = n % H_TOTAL;
      y = (n / H_TOTAL) % V_TOTAL;
      e.hsd = (x >= H_SYNC);
      e.vsd = (y >= V_SYNC);
      e.fs  = (x == 0) && (y == 0);
      e.rgb = in_nes(x, y) ? pal_ref(fb_idx((x - H_ACT0 - 144) / 2, (y - V_ACT0) / 2)) : 24'h0;
      return e;
   endfunction

   // Stimulus-side scoreboard push plus a synchronous-read frame buffer.
   always @(posedge i_lcd_clk or posedge i_rst) begin
      if (i_rst) begin
         edges = 0;
         q.delete();
      end else begin
         edges++;
         q.push_back(model(edges - 1));
         en_s = i_en;
         if (o_pix_rd) i_pix_idx <= fb_idx(int'(o_pix_rx), int'(o_pix_ry));
      end
   end

   always @(negedge i_lcd_clk) begin
      exp_t e;
      int   n;
      logic exp_rd;
      if (i_rst) begin
         last_rx = 0; last_ry = 0; rd_cnt = 0; fs_last = -1; hs_low = 0; vs_low = 0;
      end else begin
         if (edges >= 3) begin
            if (q.size() == 0) begin
               check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               check("hsd", 32'(o_hsd), 32'(e.hsd));
               check("vsd", 32'(o_vsd), 32'(e.vsd));
               check("frame_start", 32'(o_frame_start), 32'(e.fs));
               check("rgb", 32'({o_r, o_g, o_b}), 32'(en_s ? e.rgb : 24'h0));
            end
         end else begin
            check("idle_hsd", 32'(o_hsd), 32'd1);
            check("idle_vsd", 32'(o_vsd), 32'd1);
            check("idle_fs", 32'(o_frame_start), 32'd0);
            check("idle_rgb", 32'({o_r, o_g, o_b}), 32'd0);
         end

         n = edges;
         exp_rd = (n > 0) && in_nes(n % H_TOTAL, (n / H_TOTAL) % V_TOTAL);
         check("pix_rd", 32'(o_pix_rd), 32'(exp_rd));
         if (exp_rd) begin
            last_rx = ((n % H_TOTAL) - H_ACT0 - 144) / 2;
            last_ry = (((n / H_TOTAL) % V_TOTAL) - V_ACT0) / 2;
         end
         check("pix_rx", 32'(o_pix_rx), 32'(last_rx));
         check("pix_ry", 32'(o_pix_ry), 32'(last_ry));

         if (n > 0 && n % FRAME == 0) begin
            check("reads_per_frame", 32'(rd_cnt), 32'(rd_exp_frame));
            rd_cnt = 0;
         end
         if (o_pix_rd) rd_cnt++;

         if (o_frame_start) begin
            if (fs_last >= 0) begin
               check("frame_period", 32'(edges - fs_last), 32'(FRAME));
               check("hsd_low_per_frame", 32'(hs_low), 32'(H_SYNC * V_TOTAL));
               check("vsd_low_per_frame", 32'(vs_low), 32'(V_SYNC * H_TOTAL));
            end
            fs_last = edges;
            hs_low = 0;
            vs_low = 0;
         end
         if (!o_hsd) hs_low++;
         if (!o_vsd) vs_low++;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_hsd"}, 32'(o_hsd), 32'd1);
      check({tag, "_vsd"}, 32'(o_vsd), 32'd1);
      check({tag, "_rgb"}, 32'({o_r, o_g, o_b}), 32'd0);
      check({tag, "_rd"}, 32'(o_pix_rd), 32'd0);
      check({tag, "_rx"}, 32'(o_pix_rx), 32'd0);
      check({tag, "_ry"}, 32'(o_pix_ry), 32'd0);
      check({tag, "_fs"}, 32'(o_frame_start), 32'd0);
   endtask

   task automatic release_and_check();
      int k;
      @(negedge i_lcd_clk);
      i_rst = 1'b0;
      k = 0;
      while (!o_frame_start && k < 10) begin
         @(negedge i_lcd_clk);
         k++;
      end
      check("first_fs_latency", 32'(edges), 32'd3);
   endtask

   initial begin
      int guard;
      rd_exp_frame = 0;
      for (int y = 0; y < V_TOTAL; y++)
         if (y >= V_ACT0 && y <= V_ACT0 + 479) rd_exp_frame += 512;
      seed = int'($urandom_range(0, 1023));

      i_rst = 1'b1;
      i_en  = 1'b1;
      mode  = 0;
      repeat (3) @(negedge i_lcd_clk);
      check_reset_outputs("reset");

      release_and_check();
      repeat (2 * FRAME + 10) @(negedge i_lcd_clk);

      mode = 1;
      repeat (FRAME) @(negedge i_lcd_clk);

      mode = 2;
      for (int k = 0; k < (2 * FRAME) / 50; k++) begin
         repeat (50) @(negedge i_lcd_clk);
         i_en = ($urandom_range(0, 3) != 0);
      end
      i_en = 1'b1;

      // Reset in the middle of an active NES line.
      mode = 0;
      guard = 0;
      while (!(((edges - 3) % H_TOTAL) == 400 && (((edges - 3) / H_TOTAL) % V_TOTAL) == 7)
             && guard < 2 * FRAME) begin
         @(negedge i_lcd_clk);
         guard++;
      end
      check("reset_target_reached", 32'(guard < 2 * FRAME), 32'd1);
      check("pre_reset_rgb", 32'({o_r, o_g, o_b}), 32'hFFFFFF);
      #2 i_rst = 1'b1;
      #1 check_reset_outputs("async_reset");
      repeat (4) @(negedge i_lcd_clk);
      check_reset_outputs("held_reset");
      release_and_check();
      repeat (FRAME + 20) @(negedge i_lcd_clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mtl_lcd_ctrl.md
MTL_LCD_CTRL -- requirements
Module: mtl_lcd_ctrl

Interface
REQ-001 SHALL have parameter H_TOTAL, default 1056, meaning pixel clocks per line.
REQ-002 SHALL have parameter V_TOTAL, default 525, meaning lines per frame.
REQ-003 SHALL have parameter H_ACT0, default 50, meaning first active column (output-aligned).
REQ-004 SHALL have parameter V_ACT0, default 23, meaning first active line.
REQ-005 SHALL have parameter H_SYNC, default 30, meaning HSD low width in clocks.
REQ-006 SHALL have parameter V_SYNC, default 13, meaning VSD low width in lines.
REQ-007 SHALL have port i_lcd_clk, input, 1 bit, meaning pixel clock, which is also MTL_DCLK.
REQ-008 SHALL have port i_rst, input, 1 bit, meaning asynchronous active-high reset; this clock and reset arrangement is already decided.
REQ-009 SHALL have port i_en, input, 1 bit, meaning display enable; when low, RGB is forced to black and timing keeps running.
REQ-010 SHALL have port o_pix_rx, output, 8 bits, meaning NES column read address to the frame buffer.
REQ-011 SHALL have port o_pix_ry, output, 8 bits, meaning NES row read address.
REQ-012 SHALL have port o_pix_rd, output, 1 bit, meaning read strobe.
REQ-013 SHALL have port i_pix_idx, input, 6 bits, meaning palette index, valid exactly 1 clock after o_pix_rd.
REQ-014 SHALL have port o_hsd, output, 1 bit, meaning active-low horizontal sync.
REQ-015 SHALL have port o_vsd, output, 1 bit, meaning active-low vertical sync.
REQ-016 SHALL have ports o_r, o_g and o_b, output, 8 bits each, meaning pixel colour.
REQ-017 SHALL have port o_frame_start, output, 1 bit, meaning a 1-clock pulse at the start of each frame.

Function
REQ-018 SHALL run internal counters xcnt (0..H_TOTAL-1) and line (0..V_TOTAL-1); xcnt wraps to 0 after H_TOTAL-1, and line increments only on that wrap.
REQ-019 SHALL wrap line from V_TOTAL-1 to 0 on the same clock that xcnt wraps.
REQ-020 SHALL define the output-aligned coordinates (ox, oy) as (xcnt, line) delayed 3 clocks; all of o_hsd, o_vsd, o_r, o_g and o_b refer to (ox, oy).
REQ-021 SHALL drive o_hsd low when ox < H_SYNC and high otherwise.
REQ-022 SHALL drive o_vsd low when oy < V_SYNC and high otherwise.
REQ-023 SHALL define the active window as ox in [H_ACT0, H_ACT0+799] and oy in [V_ACT0, V_ACT0+479].
REQ-024 SHALL define the NES window as active x offset ax = ox-H_ACT0 in [144, 655]; inside it, NES pixel = ((ax-144)>>1, (oy-V_ACT0)>>1), giving 2x2 scaling of 256x240.
REQ-025 SHALL output RGB 0x000000 for every pixel outside the NES window, including all blanking.
REQ-026 SHALL issue o_pix_rd with o_pix_rx/o_pix_ry at counter stage 0 for coordinates that reach the output 3 clocks later.
REQ-027 SHALL use pipeline stage 1 to capture i_pix_idx, stage 2 to perform the palette ROM lookup, and stage 3 to register o_r/o_g/o_b.
REQ-028 SHALL keep o_pix_rd low outside the NES window.
REQ-029 SHALL hold o_pix_rx/o_pix_ry at their last value while o_pix_rd is low.
REQ-030 SHALL implement the palette ROM as 64 entries x 24 bits with fixed contents: 0x0F→0x000000, 0x20→0xFFFFFF, 0x30→0xFFFFFF, 0x16→0xB21030; the remaining entries come from the team NTSC 2C02 table.
REQ-031 SHALL force RGB to 0 when i_en is low; this gating is applied at stage 3, so it takes effect on the next clock.
REQ-032 SHALL pulse o_frame_start for the single clock on which ox==0 and oy==0.

Reset
REQ-033 SHALL, while i_rst is high, force xcnt=0, line=0, all pipeline registers to 0, o_hsd=1, o_vsd=1, RGB=0, o_pix_rd=0, o_pix_rx=0, o_pix_ry=0 and o_frame_start=0.
REQ-034 SHALL start counting on the first i_lcd_clk rising edge after i_rst deasserts; the first o_frame_start occurs 3 clocks later.
REQ-035 SHALL, on a mid-frame reset, abort the frame immediately, with no partial pipeline output after reset release.

Verification
REQ-036 SHALL cover: reset release, then 2 frames -> o_frame_start period 554400 clocks; o_hsd low 30 clocks per 1056; o_vsd low 13 lines per 525.
REQ-037 SHALL cover: frame buffer returning constant idx 0x30 -> RGB 0xFFFFFF exactly for ox 194..705 and oy 23..502; 0x000000 elsewhere.
REQ-038 SHALL cover: frame buffer returning idx = x[5:0] -> each index appears on 2 consecutive columns; NES column 255 maps to ox 704..705.
REQ-039 SHALL cover: read strobe check -> o_pix_rd count per frame = 512*480 = 245760; o_pix_ry sequence 0,0,1,1,...,239,239 across lines.
REQ-040 SHALL cover: i_en dropped mid-line -> RGB 0 from the next clock; o_hsd/o_vsd unaffected.
REQ-041 SHALL cover: i_rst asserted at ox=400, oy=200 -> outputs take reset values asynchronously; after release, o_frame_start appears 3 clocks later.
